// File: rtl/wb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_fifo
//
// Wishbone-attached UART transmitter with a TX FIFO. Bytes written to DATA are
// queued and then serialised 8N1 on tx_o. Optional parity is available when
// the design is built with the UART_TX_PARITY_EN macro. Baud divisor and stop
// bit count are run-time registers.
//
// Register map (adr_i):
//   0x00 DATA    W: push byte            R: last byte accepted into the FIFO
//   0x01 STATUS  R: [0] idle [1] full [2] empty [3] overflow (sticky)
//                W: bit3=1 clears overflow, bit4=1 flushes the FIFO
//   0x02 DIV_LO  0x03 DIV_HI   bit period = divisor+1 clk_i cycles
//   0x04 CONF    [0] irq on empty [1] 2 stop bits [2] parity en [3] odd parity
//   others       read 0x00, writes ignored (still acked)
//
// Ports:
//   clk_i  system clock              rst_i  async reset, active low
//   stb_i  Wishbone strobe           we_i   Wishbone write enable
//   adr_i  register address (5 b)    dat_i  write data (8 b)
//   dat_o  read data, valid with ack ack_o  registered acknowledge
//   tx_o   serial output, idle high  irq_o  registered level interrupt
//
// Configuration macro: UART_TX_PARITY_EN
//   defined     -> PARITY state and CONF[3:2] implemented
//   not defined -> no PARITY state, CONF[3:2] read 0 and ignore writes
// -----------------------------------------------------------------------------
module wb_uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 433
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [4:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       tx_o,
  output logic       irq_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EXT_W = (DIV_W > 16) ? DIV_W : 16;

  localparam logic [4:0] ADR_DATA   = 5'h00;
  localparam logic [4:0] ADR_STATUS = 5'h01;
  localparam logic [4:0] ADR_DIV_LO = 5'h02;
  localparam logic [4:0] ADR_DIV_HI = 5'h03;
  localparam logic [4:0] ADR_CONF   = 5'h04;

`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] CONF_MASK = 4'hF;
`else
  localparam logic [3:0] CONF_MASK = 4'h3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Reset synchroniser: assertion is immediate, release is aligned to clk_i.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Bus side
  logic             ack_q, ack_d;
  logic [7:0]       dat_q, dat_d;
  logic             irq_q, irq_d;
  logic [7:0]       last_q, last_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       conf_q, conf_d;
  logic             ovf_q, ovf_d;

  // FIFO
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  // Transmitter
  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] frame_div_q, frame_div_d;
  logic             frame_two_stop_q, frame_two_stop_d;
`ifdef UART_TX_PARITY_EN
  logic             frame_par_en_q, frame_par_en_d;
  logic             parity_q, parity_d;
`endif

  logic             wb_access, wr_access, rd_access;
  logic             push_req, push_ok, pop, flush;
  logic             empty, full, fsm_idle;
  logic [7:0]       head;
  logic [7:0]       rd_data;
  logic [EXT_W-1:0] div_ext, div_new;
  logic             bit_done, load_frame;

  // A held strobe is serviced only while ack is low, giving one action per ack.
  assign wb_access = stb_i & ~ack_q;
  assign wr_access = wb_access & we_i;
  assign rd_access = wb_access & ~we_i;
  assign push_req  = wr_access && (adr_i == ADR_DATA);
  assign flush     = wr_access && (adr_i == ADR_STATUS) && dat_i[4];

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fsm_idle = (state_q == ST_IDLE);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push at full is then accepted.
  assign push_ok  = push_req & (~full | pop);

  // Register file, FIFO pointers and the Wishbone read path.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    conf_d   = conf_q;
    ovf_d    = ovf_q;
    rd_data  = 8'h00;

    div_ext = '0;
    div_ext[DIV_W-1:0] = div_q;
    div_new = div_ext;

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      last_d   = dat_i;
    end
    if (push_req && !push_ok) ovf_d = 1'b1;

    // Flush drops everything still queued; the shifter keeps its byte.
    if (flush) rd_ptr_d = wr_ptr_q;
    if (wr_access && (adr_i == ADR_STATUS) && dat_i[3]) ovf_d = 1'b0;

    if (wr_access && (adr_i == ADR_DIV_LO)) div_new[7:0]  = dat_i;
    if (wr_access && (adr_i == ADR_DIV_HI)) div_new[15:8] = dat_i;
    div_d = div_new[DIV_W-1:0];

    if (wr_access && (adr_i == ADR_CONF)) conf_d = dat_i[3:0] & CONF_MASK;

    case (adr_i)
      ADR_DATA:   rd_data = last_q;
      ADR_STATUS: rd_data = {4'b0000, ovf_q, empty, full, empty & fsm_idle};
      ADR_DIV_LO: rd_data = div_ext[7:0];
      ADR_DIV_HI: rd_data = div_ext[15:8];
      ADR_CONF:   rd_data = {4'b0000, conf_q};
      default:    rd_data = 8'h00;
    endcase

    ack_d = wb_access;
    dat_d = rd_access ? rd_data : 8'h00;
    irq_d = (conf_q[0] & empty & fsm_idle) | ovf_q;
  end

  // Transmit FSM. Frame settings are captured whenever a frame is loaded,
  // so register writes during a frame only affect the following one.
  always_comb begin
    state_d          = state_q;
    shift_d          = shift_q;
    bit_cnt_d        = bit_cnt_q;
    stop_cnt_d       = stop_cnt_q;
    timer_d          = timer_q;
    frame_div_d      = frame_div_q;
    frame_two_stop_d = frame_two_stop_q;
`ifdef UART_TX_PARITY_EN
    frame_par_en_d   = frame_par_en_q;
    parity_d         = parity_q;
`endif
    pop        = 1'b0;
    load_frame = 1'b0;
    bit_done   = (timer_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (!empty) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          timer_d   = frame_div_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          timer_d = frame_div_q;
          if (bit_cnt_q == 3'd7) begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            if (frame_par_en_q) state_d = ST_PARITY;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          timer_d    = frame_div_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          if (frame_two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            timer_d    = frame_div_q;
          end else if (!empty) begin
            load_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared by IDLE and the end of STOP so back-to-back frames have no gap.
    if (load_frame) begin
      pop              = 1'b1;
      state_d          = ST_START;
      shift_d          = head;
      timer_d          = div_q;
      frame_div_d      = div_q;
      frame_two_stop_d = conf_q[1];
`ifdef UART_TX_PARITY_EN
      frame_par_en_d   = conf_q[2];
      parity_d         = (^head) ^ conf_q[3];
`endif
    end

    // tx_o is registered from the next state to keep the line glitch-free.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // FIFO storage has no reset; the pointers alone define its contents.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q            <= 1'b0;
      dat_q            <= 8'h00;
      irq_q            <= 1'b0;
      last_q           <= 8'h00;
      div_q            <= DIV_W'(DIV_RESET);
      conf_q           <= 4'h0;
      ovf_q            <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      state_q          <= ST_IDLE;
      tx_q             <= 1'b1;
      shift_q          <= 8'h00;
      bit_cnt_q        <= 3'd0;
      stop_cnt_q       <= 1'b0;
      timer_q          <= '0;
      frame_div_q      <= '0;
      frame_two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      frame_par_en_q   <= 1'b0;
      parity_q         <= 1'b0;
`endif
    end else begin
      ack_q            <= ack_d;
      dat_q            <= dat_d;
      irq_q            <= irq_d;
      last_q           <= last_d;
      div_q            <= div_d;
      conf_q           <= conf_d;
      ovf_q            <= ovf_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      state_q          <= state_d;
      tx_q             <= tx_d;
      shift_q          <= shift_d;
      bit_cnt_q        <= bit_cnt_d;
      stop_cnt_q       <= stop_cnt_d;
      timer_q          <= timer_d;
      frame_div_q      <= frame_div_d;
      frame_two_stop_q <= frame_two_stop_d;
`ifdef UART_TX_PARITY_EN
      frame_par_en_q   <= frame_par_en_d;
      parity_q         <= parity_d;
`endif
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = irq_q;
  assign tx_o  = tx_q;

endmodule

// File: tb/tb_wb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_wb_uart_tx_fifo
//
// Directed bench for wb_uart_tx_fifo. Expected frames are queued when a byte
// is written and checked by a serial monitor as the DUT shifts them out.
// -----------------------------------------------------------------------------
module tb_wb_uart_tx_fifo;

  localparam logic [4:0] ADR_DATA   = 5'h00;
  localparam logic [4:0] ADR_STATUS = 5'h01;
  localparam logic [4:0] ADR_DIV_LO = 5'h02;
  localparam logic [4:0] ADR_DIV_HI = 5'h03;
  localparam logic [4:0] ADR_CONF   = 5'h04;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       stb_i = 1'b0;
  logic       we_i  = 1'b0;
  logic [4:0] adr_i = 5'h00;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       tx_o;
  logic       irq_o;

  int     checks    = 0;
  int     errors    = 0;
  int     cyc       = 0;
  bit     monitorOn = 1'b0;
  frame_t sb[$];
  int     startCycs[$];

  wb_uart_tx_fifo dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .stb_i (stb_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .ack_o (ack_o),
    .tx_o  (tx_o),
    .irq_o (irq_o)
  );

  // 100 MHz clock
  initial forever #5 clk_i = ~clk_i;

  // Free-running cycle count used to time frame starts and latency
  always @(posedge clk_i) cyc <= cyc + 1;

  // Hard stop in case something wedges
  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Build the serial bit pattern of one frame, start bit in bit 0
  function automatic frame_t makeFrame(input logic [7:0] data, input int div,
                                       input bit parEn, input bit odd, input bit twoStop);
    frame_t f;
    int idx;
    f.bits = '0;
    f.bits[0] = 1'b0;
    f.bits[8:1] = data;
    idx = 9;
    if (parEn) begin
      f.bits[idx] = (^data) ^ odd;
      idx++;
    end
    f.bits[idx] = 1'b1;
    idx++;
    if (twoStop) begin
      f.bits[idx] = 1'b1;
      idx++;
    end
    f.nbits = idx;
    f.div   = div;
    return f;
  endfunction

  task automatic pushExp(input logic [7:0] data, input int div,
                         input bit parEn, input bit odd, input bit twoStop);
    sb.push_back(makeFrame(data, div, parEn, odd, twoStop));
  endtask

  task automatic applyStimulus(input logic [4:0] adr, input logic [7:0] data, output int ackCycle);
    @(negedge clk_i);
    stb_i = 1'b1; we_i = 1'b1; adr_i = adr; dat_i = data;
    @(posedge clk_i);
    #1;
    checkOutput("write ack", {31'd0, ack_o}, 32'd1);
    ackCycle = cyc;
    @(negedge clk_i);
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] adr, output logic [7:0] data);
    @(negedge clk_i);
    stb_i = 1'b1; we_i = 1'b0; adr_i = adr;
    @(posedge clk_i);
    #1;
    data = ack_o ? dat_o : 8'hxx;
    @(negedge clk_i);
    stb_i = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    logic [7:0] s;
    int polls;
    polls = 0;
    do begin
      readReg(ADR_STATUS, s);
      polls++;
    end while (s !== 8'h05 && polls < 4000);
    checkOutput(tag, {24'd0, s}, 32'h05);
    checkOutput({tag, " drained"}, sb.size(), 32'd0);
  endtask

  // Serial monitor: on each start bit pop the next expected frame and sample
  // every bit in the middle of its period.
  initial begin : monitor
    frame_t      exp;
    logic [11:0] obs;
    int          guard;
    forever begin
      @(negedge clk_i);
      if (monitorOn && rst_i && tx_o === 1'b0) begin
        checkOutput("frame expected at start bit", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() == 0) begin
          guard = 0;
          while (tx_o === 1'b0 && guard < 4000) begin
            @(negedge clk_i);
            guard++;
          end
        end else begin
          exp = sb.pop_front();
          startCycs.push_back(cyc);
          obs = '0;
          repeat (exp.div / 2) @(negedge clk_i);
          for (int b = 0; b < exp.nbits; b++) begin
            if (b > 0) repeat (exp.div + 1) @(negedge clk_i);
            obs[b] = tx_o;
          end
          checkOutput("frame bits", {20'd0, obs}, {20'd0, exp.bits});
        end
      end
    end
  end

  // Directed sequence
  initial begin : stimulus
    logic [7:0] rd;
    int         ackCyc;
    int         lat;

    // Reset values while held in reset
    #23;
    checkOutput("reset tx_o", {31'd0, tx_o}, 32'd1);
    checkOutput("reset ack_o", {31'd0, ack_o}, 32'd0);
    checkOutput("reset irq_o", {31'd0, irq_o}, 32'd0);
    checkOutput("reset dat_o", {24'd0, dat_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    monitorOn = 1'b1;

    // Register values after reset
    readReg(ADR_STATUS, rd); checkOutput("status after reset", {24'd0, rd}, 32'h05);
    readReg(ADR_DIV_LO, rd); checkOutput("div_lo after reset", {24'd0, rd}, 32'hB1);
    readReg(ADR_DIV_HI, rd); checkOutput("div_hi after reset", {24'd0, rd}, 32'h01);
    readReg(ADR_CONF, rd);   checkOutput("conf after reset", {24'd0, rd}, 32'h00);
    readReg(5'h1F, rd);      checkOutput("unmapped read", {24'd0, rd}, 32'h00);

    // Single frame 0xAA at divisor 3 plus write-to-start latency
    applyStimulus(ADR_DIV_LO, 8'h03, ackCyc);
    applyStimulus(ADR_DIV_HI, 8'h00, ackCyc);
    readReg(ADR_DIV_HI, rd); checkOutput("div_hi written", {24'd0, rd}, 32'h00);
    startCycs.delete();
    pushExp(8'hAA, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(ADR_DATA, 8'hAA, ackCyc);
    waitIdle("idle after 0xAA");
    lat = startCycs.size() > 0 ? startCycs[0] - ackCyc : 99;
    checkOutput("start latency within 2", (lat >= 1 && lat <= 2) ? 32'd1 : 32'd0, 32'd1);
    readReg(ADR_DATA, rd); checkOutput("data readback", {24'd0, rd}, 32'hAA);

    // Three queued bytes go out back to back
    startCycs.delete();
    pushExp(8'h01, 3, 1'b0, 1'b0, 1'b0);
    pushExp(8'h02, 3, 1'b0, 1'b0, 1'b0);
    pushExp(8'h03, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(ADR_DATA, 8'h01, ackCyc);
    applyStimulus(ADR_DATA, 8'h02, ackCyc);
    applyStimulus(ADR_DATA, 8'h03, ackCyc);
    waitIdle("idle after burst");
    checkOutput("frame count burst", startCycs.size(), 32'd3);
    checkOutput("gap frame1-2", startCycs.size() > 1 ? startCycs[1] - startCycs[0] : 0, 32'd40);
    checkOutput("gap frame2-3", startCycs.size() > 2 ? startCycs[2] - startCycs[1] : 0, 32'd40);

    // Held strobe: ack every other cycle, two pushes in three cycles
    pushExp(8'h5A, 3, 1'b0, 1'b0, 1'b0);
    pushExp(8'h5A, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    stb_i = 1'b1; we_i = 1'b1; adr_i = ADR_DATA; dat_i = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      checkOutput("held stb ack", {31'd0, ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk_i);
    stb_i = 1'b0; we_i = 1'b0;
    waitIdle("idle after held stb");

    // Fill past full while a slow frame occupies the shifter
    applyStimulus(ADR_DIV_LO, 8'd200, ackCyc);
    pushExp(8'h10, 200, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) pushExp(8'h10 + 8'(i), 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 17; i++) applyStimulus(ADR_DATA, 8'h10 + 8'(i), ackCyc);
    readReg(ADR_STATUS, rd); checkOutput("status full+overflow", {24'd0, rd}, 32'h0A);
    checkOutput("irq on overflow", {31'd0, irq_o}, 32'd1);
    readReg(ADR_DATA, rd); checkOutput("last accepted byte", {24'd0, rd}, 32'h20);
    applyStimulus(ADR_DIV_LO, 8'h00, ackCyc);
    applyStimulus(ADR_STATUS, 8'h08, ackCyc);
    readReg(ADR_STATUS, rd); checkOutput("overflow cleared", {24'd0, rd}, 32'h02);
    checkOutput("irq after clear", {31'd0, irq_o}, 32'd0);
    waitIdle("idle after drain");

    // Flush drops queued bytes but the byte in flight completes
    applyStimulus(ADR_DIV_LO, 8'd50, ackCyc);
    pushExp(8'hC1, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus(ADR_DATA, 8'hC1, ackCyc);
    applyStimulus(ADR_DATA, 8'hC2, ackCyc);
    applyStimulus(ADR_DATA, 8'hC3, ackCyc);
    applyStimulus(ADR_STATUS, 8'h10, ackCyc);
    readReg(ADR_STATUS, rd); checkOutput("status after flush", {24'd0, rd}, 32'h04);
    waitIdle("idle after flush");

    // Empty interrupt enable
    applyStimulus(ADR_CONF, 8'h01, ackCyc);
    readReg(ADR_CONF, rd); checkOutput("conf irq en", {24'd0, rd}, 32'h01);
    checkOutput("irq empty enabled", {31'd0, irq_o}, 32'd1);
    applyStimulus(ADR_CONF, 8'h00, ackCyc);
    readReg(ADR_CONF, rd);
    checkOutput("irq empty disabled", {31'd0, irq_o}, 32'd0);

    // Parity and stop bit configuration at divisor 1
    applyStimulus(ADR_DIV_LO, 8'h01, ackCyc);
`ifdef UART_TX_PARITY_EN
    applyStimulus(ADR_CONF, 8'h0C, ackCyc);
    readReg(ADR_CONF, rd); checkOutput("conf odd parity", {24'd0, rd}, 32'h0C);
    pushExp(8'h07, 1, 1'b1, 1'b1, 1'b0);
    applyStimulus(ADR_DATA, 8'h07, ackCyc);
    waitIdle("idle after odd parity");
    applyStimulus(ADR_CONF, 8'h06, ackCyc);
    pushExp(8'h07, 1, 1'b1, 1'b0, 1'b1);
    applyStimulus(ADR_DATA, 8'h07, ackCyc);
    waitIdle("idle after even parity");
`else
    applyStimulus(ADR_CONF, 8'h0E, ackCyc);
    readReg(ADR_CONF, rd); checkOutput("conf parity bits masked", {24'd0, rd}, 32'h02);
    pushExp(8'h07, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(ADR_DATA, 8'h07, ackCyc);
    waitIdle("idle after two stop");
    applyStimulus(ADR_CONF, 8'h0C, ackCyc);
    readReg(ADR_CONF, rd); checkOutput("conf parity ignored", {24'd0, rd}, 32'h00);
    pushExp(8'h07, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(ADR_DATA, 8'h07, ackCyc);
    waitIdle("idle after no parity");
`endif
    applyStimulus(ADR_CONF, 8'h00, ackCyc);

    // Reset in the middle of the data bits
    monitorOn = 1'b0;
    applyStimulus(ADR_DIV_LO, 8'h03, ackCyc);
    applyStimulus(ADR_DATA, 8'h00, ackCyc);
    repeat (10) @(posedge clk_i);
    #2;
    checkOutput("tx low mid-frame", {31'd0, tx_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("tx high in reset", {31'd0, tx_o}, 32'd1);
    checkOutput("ack low in reset", {31'd0, ack_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    sb.delete();
    readReg(ADR_STATUS, rd); checkOutput("status after mid-frame reset", {24'd0, rd}, 32'h05);
    readReg(ADR_DIV_LO, rd); checkOutput("div_lo after mid-frame reset", {24'd0, rd}, 32'hB1);
    checkOutput("tx idle after reset", {31'd0, tx_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
